fifo_out_arbiter: RTL

- Shares one byte-wide output transmitter (out_start/out_finish handshake) between N_SRC first-word-fall-through byte FIFOs.
- Round-robin arbitration with an optional burst allowance per grant.
- Sits between the per-channel FIFOs and the single output device.
- Replaces per-channel drain logic with one scheduler: one FIFO pop and one transmit per byte.

---
 rtl/fifo_out_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_out_arbiter.sv
// fifo_out_arbiter: round-robin scheduler that drains N_SRC first-word-fall-through
// byte FIFOs into one shared transmitter, one pop and one transmit per byte, with an
// optional burst allowance before priority rotates.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | post-reset, nothing owned; moves to ARB next cycle
// ARB       | wait for transmitter idle and a request, pick the owner
// POP       | pop strobe was issued with the byte latched; raise out_start
// START     | out_start up; check whether the transmitter already took it
// WAIT_ACC  | transmitter has not yet dropped out_finish
// WAIT_DONE | byte in flight; wait for out_finish to return high
module fifo_out_arbiter #(
   parameter int N_SRC     = 3,
   parameter int MAX_BURST = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N_SRC-1:0]     fifo_empty,
   input  logic [N_SRC-1:0]     fifo_busy,
   input  logic [8*N_SRC-1:0]   fifo_data,
   output logic [N_SRC-1:0]     fifo_re,
   output logic [7:0]           out_data,
   output logic                 out_start,
   input  logic                 out_finish,
   output logic [N_SRC-1:0]     grant,
   output logic                 isFinish,
   output logic [2:0]           state
);

   localparam int SW = $clog2(N_SRC);
   localparam logic [3:0] MAX_B = 4'(MAX_BURST);
   localparam logic [SW-1:0] LAST_RST = SW'(N_SRC - 1);
   localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARB       = 3'd1,
      POP       = 3'd2,
      START     = 3'd3,
      WAIT_ACC  = 3'd4,
      WAIT_DONE = 3'd5
   } st_t;

   st_t              st;
   logic [SW-1:0]    last_src;
   logic [SW-1:0]    owner;
   logic [SW-1:0]    rr_idx;
   logic [SW-1:0]    sel;
   logic [3:0]       burst_cnt;
   logic [N_SRC-1:0] req;
   logic             rr_found;
   logic             keep;
   logic [7:0]       src_byte [N_SRC];

   assign req   = ~fifo_empty & ~fifo_busy;
   assign state = st;

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_byte
      assign src_byte[gi] = fifo_data[8*gi +: 8];
   end

   // round-robin search starting just after the last owner
   always_comb begin : rr_pick
      int idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(last_src) + k) % N_SRC;
         if (!rr_found && req[SW'(idx)]) begin
            rr_found = 1'b1;
            rr_idx   = SW'(idx);
         end
      end
   end

   // burst continuation wins over rotation while the owner keeps requesting
   always_comb begin
      keep = (burst_cnt != 4'd0) && req[last_src] && (burst_cnt < MAX_B);
      sel  = keep ? last_src : rr_idx;
   end

   // scheduler FSM with registered outputs; enable low freezes everything but the pop strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         fifo_re   <= '0;
         out_data  <= '0;
         out_start <= 1'b0;
         grant     <= '0;
         isFinish  <= 1'b1;
         last_src  <= LAST_RST;
         owner     <= '0;
         burst_cnt <= '0;
      end else if (!enable) begin
         fifo_re <= '0;
      end else begin
         fifo_re <= '0;
         case (st)
            IDLE: begin
               isFinish <= 1'b1;
               grant    <= '0;
               st       <= ARB;
            end
            ARB: begin
               if (out_finish && rr_found) begin
                  if (!keep) begin
                     burst_cnt <= '0;
                  end
                  owner    <= sel;
                  out_data <= src_byte[sel];
                  grant    <= ONE << sel;
                  fifo_re  <= ONE << sel;
                  isFinish <= 1'b0;
                  st       <= POP;
               end else if (!rr_found && burst_cnt != 4'd0) begin
                  burst_cnt <= '0;
                  grant     <= '0;
                  isFinish  <= 1'b1;
               end
            end
            POP: begin
               out_start <= 1'b1;
               st        <= START;
            end
            START: begin
               st <= out_finish ? WAIT_ACC : WAIT_DONE;
            end
            WAIT_ACC: begin
               if (!out_finish) begin
                  st <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (out_finish) begin
                  out_start <= 1'b0;
                  last_src  <= owner;
                  if (burst_cnt < MAX_B) begin
                     burst_cnt <= burst_cnt + 4'd1;
                  end
                  st <= ARB;
               end
            end
            default: begin
               st <= IDLE;
            end
         endcase
      end
   end

endmodule
